dmem_port_arbiter: RTL and testbench

Shares the single-port data RAM (8-bit address, 8-bit data) between the CPU load/store path and the Ethernet receive byte stream.
- Ethernet bytes are buffered in a small FIFO and written into a circular receive window starting at ETH_BASE.
- The CPU has priority, except when the FIFO is full; then the CPU is stalled for one cycle.
- At end of frame the block reports the frame length to the core.

---
 rtl/dmem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-RAM port arbiter: CPU load/store path has priority; Ethernet receive bytes are
// buffered in a small FIFO and written into a circular window, with frame length reporting.
module dmem_port_arbiter #(
  parameter logic [7:0] ETH_BASE   = 8'hF0,
  parameter int         ETH_WIN    = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cpu_req,
  input  logic       i_cpu_we,
  input  logic [7:0] i_cpu_addr,
  input  logic [7:0] i_cpu_wdata,
  output logic       o_cpu_stall,
  input  logic       i_eth_valid,
  input  logic [7:0] i_eth_data,
  input  logic       i_eth_sof,
  input  logic       i_eth_eof,
  output logic       o_eth_ready,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_wdata,
  output logic       o_mem_wren,
  output logic       o_frame_done,
  output logic [7:0] o_frame_len,
  output logic       o_frame_ovf,
  output logic [1:0] o_dbg_state
);

  // Handshake: an Ethernet byte transfers on a cycle where i_eth_valid and o_eth_ready
  // are both high; o_eth_ready never depends on i_eth_valid.

  localparam int WPW = $clog2(ETH_WIN);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_FLUSH, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_fifo [FIFO_DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_fcnt;
  logic [WPW-1:0] r_wp;
  logic [7:0]     r_bcnt;
  logic           r_ovf;
  logic [7:0]     r_frame_len;
  logic           r_frame_ovf;

  logic w_full;
  logic w_pend;
  logic w_accept;
  logic w_push;
  logic w_restart;
  logic w_cpu_gnt;
  logic w_eth_gnt;

  assign w_full   = (r_fcnt == CW'(FIFO_DEPTH));
  assign w_pend   = (r_fcnt != '0);
  assign o_eth_ready = (r_state == S_IDLE) || ((r_state == S_FRAME) && !w_full);
  assign w_accept = i_eth_valid && o_eth_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_restart    = 1'b0;
    o_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Bytes arriving outside a frame are dropped until a start-of-frame shows up.
        if (w_accept && i_eth_sof) begin
          w_push      = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = i_eth_eof ? S_FLUSH : S_FRAME;
        end
      end
      S_FRAME: begin
        if (w_accept) begin
          w_push    = 1'b1;
          w_restart = i_eth_sof;
          if (i_eth_eof) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!w_pend) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign o_dbg_state = r_state;

  // A full FIFO steals the port for one cycle; the pop then frees a slot.
  assign w_cpu_gnt   = i_cpu_req && !(w_full && w_pend);
  assign w_eth_gnt   = w_pend && !w_cpu_gnt;
  assign o_cpu_stall = i_cpu_req && !w_cpu_gnt;

  always_comb begin
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = 8'h00;
    o_mem_wren  = 1'b0;
    if (w_cpu_gnt) begin
      o_mem_wdata = i_cpu_wdata;
      o_mem_wren  = i_cpu_we;
    end else if (w_eth_gnt) begin
      o_mem_addr  = ETH_BASE + {{(8-WPW){1'b0}}, r_wp};
      o_mem_wdata = r_fifo[r_rd_ptr];
      o_mem_wren  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[w_restart ? '0 : r_wr_ptr] <= i_eth_data;
  end

  // A restart flushes whatever the aborted frame left queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fcnt   <= '0;
    end else if (w_restart) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= AW'(1);
      r_fcnt   <= CW'(1);
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_eth_gnt) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_eth_gnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_bcnt <= '0;
      r_ovf  <= 1'b0;
    end else if (w_restart) begin
      r_wp   <= '0;
      r_bcnt <= '0;
      r_ovf  <= 1'b0;
    end else if (w_eth_gnt) begin
      r_wp <= r_wp + WPW'(1);
      if (r_wp == WPW'(ETH_WIN - 1)) r_ovf <= 1'b1;
      if (r_bcnt != 8'hFF) r_bcnt <= r_bcnt + 8'h01;
    end
  end

  // Captured on the way into DONE so the result is visible alongside the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_len <= '0;
      r_frame_ovf <= 1'b0;
    end else if ((r_state == S_FLUSH) && !w_pend) begin
      r_frame_len <= r_bcnt;
      r_frame_ovf <= r_ovf;
    end
  end

  assign o_frame_len = r_frame_len;
  assign o_frame_ovf = r_frame_ovf;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: CPU pass-through vectors, frame sequences with a write
// scoreboard, window wrap, abort, stray bytes and mid-frame reset.
module tb_dmem_port_arbiter;

  localparam logic [7:0] BASE = 8'hF0;
  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cpu_req, i_cpu_we;
  logic [7:0] i_cpu_addr, i_cpu_wdata;
  logic       o_cpu_stall;
  logic       i_eth_valid, i_eth_sof, i_eth_eof;
  logic [7:0] i_eth_data;
  logic       o_eth_ready;
  logic [7:0] o_mem_addr, o_mem_wdata;
  logic       o_mem_wren, o_frame_done, o_frame_ovf;
  logic [7:0] o_frame_len;
  logic [1:0] o_dbg_state;

  dmem_port_arbiter #(.ETH_BASE(BASE), .ETH_WIN(WIN), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_stall(o_cpu_stall),
    .i_eth_valid(i_eth_valid), .i_eth_data(i_eth_data), .i_eth_sof(i_eth_sof),
    .i_eth_eof(i_eth_eof), .o_eth_ready(o_eth_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wren(o_mem_wren),
    .o_frame_done(o_frame_done), .o_frame_len(o_frame_len), .o_frame_ovf(o_frame_ovf),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  ram [256];
  int   wr_cnt = 0, done_cnt = 0, stall_cnt = 0, stall_wr_cnt = 0, notready_cnt = 0;
  logic prev_stall = 1'b0;
  logic sb_en = 1'b0;
  int   exp_wp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_wren) begin
        ram[o_mem_addr] = o_mem_wdata;
        wr_cnt++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_write: got %0h:%0h expected none", o_mem_addr, o_mem_wdata);
          end else begin
            check("sb_write", {16'h0, o_mem_addr, o_mem_wdata}, {16'h0, exp_q.pop_front()});
          end
        end
      end
      if (o_cpu_stall) begin
        stall_cnt++;
        if (o_mem_wren) stall_wr_cnt++;
        check("stall_not_consecutive", {31'b0, prev_stall}, 32'd0);
      end
      prev_stall = o_cpu_stall;
      if (o_frame_done) done_cnt++;
      if (!o_eth_ready) notready_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Drivers
  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof);
    int t = 0;
    bit ok = 0;
    i_eth_valid = 1'b1;
    i_eth_data  = d;
    i_eth_sof   = sof;
    i_eth_eof   = eof;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (o_eth_ready) ok = 1;
      tick();
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted within 50 cycles", d);
    end else if (sb_en) begin
      exp_q.push_back({BASE + 8'(exp_wp % WIN), d});
      exp_wp++;
    end
    i_eth_valid = 1'b0;
    i_eth_sof   = 1'b0;
    i_eth_eof   = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int t = 0;
    while (done_cnt == start && t < 200) begin
      tick();
      t++;
    end
    repeat (4) tick();
    check("frame_done_once", done_cnt - start, 32'd1);
  endtask

  typedef struct {
    logic       req, we;
    logic [7:0] addr, wdata;
    logic       exp_stall, exp_wren;
    logic [7:0] exp_addr, exp_wdata;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int w0;
    rst = 1'b1;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 8'h00; i_cpu_wdata = 8'h00;
    i_eth_valid = 1'b0; i_eth_data = 8'h00; i_eth_sof = 1'b0; i_eth_eof = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    repeat (2) tick();
    check("rst_stall", {31'b0, o_cpu_stall}, 0);
    check("rst_wren", {31'b0, o_mem_wren}, 0);
    check("rst_done", {31'b0, o_frame_done}, 0);
    check("rst_len", {24'b0, o_frame_len}, 0);
    check("rst_ovf", {31'b0, o_frame_ovf}, 0);
    check("rst_ready", {31'b0, o_eth_ready}, 1);
    check("rst_state", {30'b0, o_dbg_state}, 0);
    rst = 1'b0;
    tick();

    // Vector table: CPU pass-through with the FIFO empty
    for (int i = 0; i < 8; i++) begin
      vecs[i].req   = (i < 4) ? 1'(i >> 1) : 1'($urandom_range(0, 1));
      vecs[i].we    = (i < 4) ? 1'(i) : 1'($urandom_range(0, 1));
      vecs[i].addr  = 8'($urandom_range(0, 255));
      vecs[i].wdata = 8'($urandom_range(1, 255));
      vecs[i].exp_stall = 1'b0;
      vecs[i].exp_wren  = vecs[i].req & vecs[i].we;
      vecs[i].exp_addr  = vecs[i].addr;
      vecs[i].exp_wdata = vecs[i].req ? vecs[i].wdata : 8'h00;
    end
    for (int i = 0; i < 8; i++) begin
      i_cpu_req = vecs[i].req; i_cpu_we = vecs[i].we;
      i_cpu_addr = vecs[i].addr; i_cpu_wdata = vecs[i].wdata;
      #2;
      check("vec_stall", {31'b0, o_cpu_stall}, {31'b0, vecs[i].exp_stall});
      check("vec_wren", {31'b0, o_mem_wren}, {31'b0, vecs[i].exp_wren});
      check("vec_addr", {24'b0, o_mem_addr}, {24'b0, vecs[i].exp_addr});
      check("vec_wdata", {24'b0, o_mem_wdata}, {24'b0, vecs[i].exp_wdata});
      tick();
    end
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = 8'h00; i_cpu_wdata = 8'h00;
    tick();

    // 5-byte frame, CPU idle
    sb_en = 1'b1; exp_wp = 0; d0 = done_cnt;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    wait_done(d0);
    check("f5_queue_empty", exp_q.size(), 0);
    check("f5_len", {24'b0, o_frame_len}, 5);
    check("f5_ovf", {31'b0, o_frame_ovf}, 0);
    check("f5_ram_f0", {24'b0, ram[8'hF0]}, 32'h11);
    check("f5_ram_f4", {24'b0, ram[8'hF4]}, 32'h55);

    // Same frame with the CPU loading every cycle
    for (int i = 0; i < 5; i++) ram[8'hF0 + 8'(i)] = 8'h00;
    exp_wp = 0; d0 = done_cnt;
    stall_cnt = 0; stall_wr_cnt = 0; notready_cnt = 0; w0 = wr_cnt;
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 8'h10;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    repeat (3) tick();
    check("busy_stall_seen", {31'b0, stall_cnt > 0}, 1);
    check("busy_stall_is_eth_write", stall_cnt, stall_wr_cnt);
    check("busy_writes_need_stall", wr_cnt - w0, stall_cnt);
    check("busy_ready_dropped", {31'b0, notready_cnt > 0}, 1);
    i_cpu_req = 1'b0;
    wait_done(d0);
    check("busy_queue_empty", exp_q.size(), 0);
    check("busy_len", {24'b0, o_frame_len}, 5);
    for (int i = 0; i < 5; i++)
      check("busy_ram", {24'b0, ram[8'hF0 + 8'(i)]}, 32'h11 * (i + 1));

    // 18-byte frame wraps the window
    exp_wp = 0; d0 = done_cnt;
    for (int i = 0; i < 18; i++) send_byte(8'h80 + 8'(i), i == 0, i == 17);
    wait_done(d0);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_len", {24'b0, o_frame_len}, 18);
    check("wrap_ovf", {31'b0, o_frame_ovf}, 1);
    check("wrap_ram_f0", {24'b0, ram[8'hF0]}, 32'h90);
    check("wrap_ram_f1", {24'b0, ram[8'hF1]}, 32'h91);
    check("wrap_ram_ff", {24'b0, ram[8'hFF]}, 32'h8F);

    // Aborted frame: second sof restarts the window
    sb_en = 1'b0; d0 = done_cnt;
    send_byte(8'hA1, 1'b1, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    send_byte(8'hB1, 1'b1, 1'b0);
    send_byte(8'hB2, 1'b0, 1'b1);
    wait_done(d0);
    check("abort_ram_f0", {24'b0, ram[8'hF0]}, 32'hB1);
    check("abort_ram_f1", {24'b0, ram[8'hF1]}, 32'hB2);
    check("abort_len", {24'b0, o_frame_len}, 2);
    check("abort_ovf", {31'b0, o_frame_ovf}, 0);

    // Stray bytes without sof while idle
    w0 = wr_cnt; d0 = done_cnt;
    i_eth_valid = 1'b1; i_eth_sof = 1'b0; i_eth_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ready", {31'b0, o_eth_ready}, 1);
      tick();
    end
    i_eth_valid = 1'b0;
    repeat (5) tick();
    check("stray_no_write", wr_cnt - w0, 0);
    check("stray_no_done", done_cnt - d0, 0);
    check("stray_state_idle", {30'b0, o_dbg_state}, 0);
    check("len_holds", {24'b0, o_frame_len}, 2);

    // Reset mid-frame with bytes still queued
    i_cpu_req = 1'b1;
    send_byte(8'hC1, 1'b1, 1'b0);
    send_byte(8'hC2, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    rst = 1'b1;
    i_cpu_req = 1'b0;
    #2;
    check("mid_rst_ready", {31'b0, o_eth_ready}, 1);
    check("mid_rst_state", {30'b0, o_dbg_state}, 0);
    check("mid_rst_done", {31'b0, o_frame_done}, 0);
    tick();
    rst = 1'b0;
    w0 = wr_cnt; d0 = done_cnt;
    repeat (10) tick();
    check("mid_rst_no_write", wr_cnt - w0, 0);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_ready_after", {31'b0, o_eth_ready}, 1);
    check("mid_rst_state_after", {30'b0, o_dbg_state}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
